// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter
// Runs request-to-send, shifts start/data/parity/stop on device clock falls, checks the ack bit.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 750000
) (
   input  logic       clock50,
   input  logic       reset_n,
   input  logic [7:0] tx_data,
   input  logic       tx_start,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_error,
   input  logic       ps2_clk_i,
   input  logic       ps2_dat_i,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe
);

   localparam int MAX_CYC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam int CW      = $clog2(MAX_CYC + 1);
   localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
   localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_INHIBIT, S_RTS, S_SHIFT, S_ACK, S_WAITIDLE, S_DONE
   } state_t;

   state_t        r_state;
   logic          r_clk_s1, r_clk_s2, r_clk_h;
   logic          r_dat_s1, r_dat_s2;
   logic [8:0]    r_sh;
   logic [3:0]    r_n;
   logic [CW-1:0] r_cnt;
   logic          r_err;
   logic          w_fall;

   // Synchronisers reset to the idle-high bus level so reset never fakes a falling edge.
   always_ff @(posedge clock50 or negedge reset_n) begin
      if (!reset_n) begin
         r_clk_s1 <= 1'b1;
         r_clk_s2 <= 1'b1;
         r_clk_h  <= 1'b1;
         r_dat_s1 <= 1'b1;
         r_dat_s2 <= 1'b1;
      end else begin
         r_clk_s1 <= ps2_clk_i;
         r_clk_s2 <= r_clk_s1;
         r_clk_h  <= r_clk_s2;
         r_dat_s1 <= ps2_dat_i;
         r_dat_s2 <= r_dat_s1;
      end
   end

   assign w_fall = r_clk_h & ~r_clk_s2;

   always_ff @(posedge clock50 or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_sh       <= '0;
         r_n        <= '0;
         r_cnt      <= '0;
         r_err      <= 1'b0;
         tx_busy    <= 1'b0;
         tx_done    <= 1'b0;
         tx_error   <= 1'b0;
         ps2_clk_oe <= 1'b0;
         ps2_dat_oe <= 1'b0;
      end else begin
         tx_done  <= 1'b0;
         tx_error <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (tx_start) begin
                  r_sh       <= {~^tx_data, tx_data};
                  r_n        <= '0;
                  r_cnt      <= '0;
                  r_err      <= 1'b0;
                  tx_busy    <= 1'b1;
                  ps2_clk_oe <= 1'b1;
                  r_state    <= S_INHIBIT;
               end
            end
            S_INHIBIT: begin
               if (r_cnt == INH_LAST) begin
                  r_cnt      <= '0;
                  ps2_dat_oe <= 1'b1;
                  r_state    <= S_RTS;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_RTS: begin
               ps2_clk_oe <= 1'b0;
               r_n        <= '0;
               r_cnt      <= '0;
               r_state    <= S_SHIFT;
            end
            S_SHIFT, S_ACK, S_WAITIDLE: begin
               if (w_fall) r_cnt <= '0;
               else        r_cnt <= r_cnt + 1'b1;

               if (r_state == S_SHIFT && w_fall) begin
                  r_n <= r_n + 4'd1;
                  if (r_n == 4'd9) begin
                     ps2_dat_oe <= 1'b0;
                     r_state    <= S_ACK;
                  end else begin
                     ps2_dat_oe <= ~r_sh[0];
                     r_sh       <= {1'b0, r_sh[8:1]};
                  end
               end
               if (r_state == S_ACK && w_fall) begin
                  r_err   <= r_dat_s2;
                  r_state <= S_WAITIDLE;
               end
               if (r_state == S_WAITIDLE && r_clk_s2 && r_dat_s2) begin
                  tx_done  <= 1'b1;
                  tx_error <= r_err;
                  tx_busy  <= 1'b0;
                  r_state  <= S_DONE;
               end
               // Device went silent: abandon the transfer and free the bus.
               if (!w_fall && r_cnt == TO_LAST) begin
                  r_err      <= 1'b1;
                  ps2_clk_oe <= 1'b0;
                  ps2_dat_oe <= 1'b0;
                  tx_done    <= 1'b1;
                  tx_error   <= 1'b1;
                  tx_busy    <= 1'b0;
                  r_state    <= S_DONE;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - directed bench for ps2_host_tx with a simple keyboard model
module tb_ps2_host_tx;
   localparam int INH = 5000;
   localparam int TO  = 1000;
   localparam int H   = 40;

   logic       clock50 = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_start = 1'b0;
   logic       tx_busy, tx_done, tx_error;
   logic       ps2_clk_oe, ps2_dat_oe;
   logic       dev_clk_low = 1'b0;
   logic       dev_dat_low = 1'b0;
   logic       ps2_clk_i, ps2_dat_i;

   int n_checks = 0;
   int n_fail   = 0;

   assign ps2_clk_i = ~(ps2_clk_oe | dev_clk_low);
   assign ps2_dat_i = ~(ps2_dat_oe | dev_dat_low);

   always #10 clock50 = ~clock50;

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
      .clock50(clock50), .reset_n(reset_n), .tx_data(tx_data), .tx_start(tx_start),
      .tx_busy(tx_busy), .tx_done(tx_done), .tx_error(tx_error),
      .ps2_clk_i(ps2_clk_i), .ps2_dat_i(ps2_dat_i),
      .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe)
   );

   task automatic send_start(input logic [7:0] d);
      @(negedge clock50);
      tx_data  = d;
      tx_start = 1'b1;
      @(negedge clock50);
      tx_start = 1'b0;
   endtask

   task automatic wait_release(output bit rel);
      rel = 1'b0;
      for (int k = 0; k < 3 * INH && !rel; k++) begin
         @(negedge clock50);
         if (!ps2_clk_oe) rel = 1'b1;
      end
   endtask

   // Keyboard model: records the 11 bits seen on data, then acks (or not) on the 11th fall.
   task automatic device(input bit nack, output logic [10:0] bits);
      bit rel;
      bits = '0;
      wait_release(rel);
      if (!rel) begin
         n_checks++; n_fail++;
         $display("FAIL device_release: clock line never released");
         return;
      end
      bits[0] = ps2_dat_i;
      repeat (H) @(negedge clock50);
      for (int b = 1; b <= 10; b++) begin
         dev_clk_low = 1'b1;
         repeat (H) @(negedge clock50);
         bits[b] = ps2_dat_i;
         dev_clk_low = 1'b0;
         repeat (H) @(negedge clock50);
      end
      if (!nack) dev_dat_low = 1'b1;
      repeat (H / 2) @(negedge clock50);
      dev_clk_low = 1'b1;
      repeat (H) @(negedge clock50);
      dev_clk_low = 1'b0;
      dev_dat_low = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit got, output logic err,
                            output bit busy_gap, output logic busy_d, output logic [1:0] oe);
      got = 1'b0; busy_gap = 1'b0; err = 1'bx; busy_d = 1'bx; oe = 2'bxx;
      for (int i = 0; i < budget && !got; i++) begin
         @(negedge clock50);
         if (tx_done) begin
            got = 1'b1; err = tx_error; busy_d = tx_busy; oe = {ps2_clk_oe, ps2_dat_oe};
         end else if (!tx_busy) begin
            busy_gap = 1'b1;
         end
      end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clock50);
      n_checks++;
      if ({tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_dat_oe} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b want 00000",
                  {tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_dat_oe});
      end
      reset_n = 1'b1;
   endtask

   task automatic test_transfer(input string name, input logic [7:0] d, input bit nack,
                                input logic [10:0] exp_bits, input logic exp_err);
      logic [10:0] bits; bit got, gap; logic err, bd; logic [1:0] oe;
      send_start(d);
      fork
         device(nack, bits);
         wait_done(4 * INH, got, err, gap, bd, oe);
      join
      n_checks++;
      if (bits !== exp_bits) begin
         n_fail++; $display("FAIL %s_bits: got %b want %b", name, bits, exp_bits);
      end
      n_checks++;
      if (got !== 1'b1 || err !== exp_err) begin
         n_fail++; $display("FAIL %s_done: done=%b err=%b want done=1 err=%b", name, got, err, exp_err);
      end
      n_checks++;
      if (gap !== 1'b0 || bd !== 1'b0) begin
         n_fail++; $display("FAIL %s_busy: gap=%b busy_at_done=%b want 0 0", name, gap, bd);
      end
      @(negedge clock50);
      n_checks++;
      if ({tx_done, tx_error, tx_busy} !== 3'b000) begin
         n_fail++; $display("FAIL %s_pulse_width: done/err/busy=%b want 000", name, {tx_done, tx_error, tx_busy});
      end
   endtask

   task automatic test_inhibit_len;
      logic [10:0] bits; bit got, gap; logic err, bd; logic [1:0] oe; int cnt;
      cnt = 0;
      send_start(8'h07);
      cnt = 1;
      fork
         device(1'b0, bits);
         wait_done(4 * INH, got, err, gap, bd, oe);
         begin
            for (int k = 0; k < 3 * INH; k++) begin
               @(negedge clock50);
               if (ps2_clk_oe) cnt++;
               else break;
            end
         end
      join
      n_checks++;
      if (cnt !== INH + 1) begin
         n_fail++; $display("FAIL inhibit_len: clk_oe high %0d cycles want %0d", cnt, INH + 1);
      end
      n_checks++;
      if (bits !== {1'b1, 1'b0, 8'h07, 1'b0} || got !== 1'b1 || err !== 1'b0) begin
         n_fail++; $display("FAIL send_07: bits=%b done=%b err=%b want %b 1 0",
                            bits, got, err, {1'b1, 1'b0, 8'h07, 1'b0});
      end
   endtask

   task automatic test_timeout;
      bit rel; int cnt;
      send_start(8'h12);
      wait_release(rel);
      cnt = 0;
      for (int k = 0; k < 3 * TO && rel; k++) begin
         @(negedge clock50);
         cnt++;
         if (tx_done) break;
      end
      n_checks++;
      if (cnt !== TO || tx_done !== 1'b1) begin
         n_fail++; $display("FAIL timeout_latency: %0d cycles done=%b want %0d 1", cnt, tx_done, TO);
      end
      n_checks++;
      if ({tx_error, ps2_clk_oe, ps2_dat_oe} !== 3'b100) begin
         n_fail++; $display("FAIL timeout_state: err/clk_oe/dat_oe=%b want 100",
                            {tx_error, ps2_clk_oe, ps2_dat_oe});
      end
   endtask

   task automatic test_start_during_shift;
      logic [10:0] bits; bit got, gap, rel; logic err, bd; logic [1:0] oe; int extra;
      send_start(8'h3C);
      fork
         device(1'b0, bits);
         wait_done(4 * INH, got, err, gap, bd, oe);
         begin
            wait_release(rel);
            repeat (200) @(negedge clock50);
            tx_data = 8'hA5; tx_start = 1'b1;
            @(negedge clock50);
            tx_start = 1'b0;
         end
      join
      extra = 0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clock50);
         if (tx_done) extra++;
      end
      n_checks++;
      if (bits !== {1'b1, 1'b1, 8'h3C, 1'b0}) begin
         n_fail++; $display("FAIL restart_bits: got %b want %b", bits, {1'b1, 1'b1, 8'h3C, 1'b0});
      end
      n_checks++;
      if (got !== 1'b1 || extra !== 0 || tx_busy !== 1'b0) begin
         n_fail++; $display("FAIL restart_single_done: done=%b extra=%0d busy=%b want 1 0 0", got, extra, tx_busy);
      end
   endtask

   task automatic test_reset_mid_shift;
      bit rel; int dones;
      send_start(8'h5A);
      wait_release(rel);
      for (int b = 0; b < 3; b++) begin
         dev_clk_low = 1'b1;
         repeat (H) @(negedge clock50);
         dev_clk_low = 1'b0;
         repeat (H) @(negedge clock50);
      end
      n_checks++;
      if (tx_busy !== 1'b1) begin
         n_fail++; $display("FAIL midshift_busy: busy=%b want 1", tx_busy);
      end
      #3 reset_n = 1'b0;
      #1;
      n_checks++;
      if ({ps2_clk_oe, ps2_dat_oe, tx_busy, tx_done} !== 4'b0000) begin
         n_fail++; $display("FAIL reset_mid_shift: clk_oe/dat_oe/busy/done=%b want 0000",
                            {ps2_clk_oe, ps2_dat_oe, tx_busy, tx_done});
      end
      dones = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clock50);
         if (tx_done) dones++;
      end
      reset_n = 1'b1;
      for (int k = 0; k < 50; k++) begin
         @(negedge clock50);
         if (tx_done) dones++;
      end
      n_checks++;
      if (dones !== 0) begin
         n_fail++; $display("FAIL reset_no_done: %0d done pulses want 0", dones);
      end
   endtask

   initial begin
      test_reset();
      test_transfer("send_ed", 8'hED, 1'b0, {1'b1, 1'b1, 8'hED, 1'b0}, 1'b0);
      test_inhibit_len();
      test_transfer("nack_ff", 8'hFF, 1'b1, {1'b1, 1'b1, 8'hFF, 1'b0}, 1'b1);
      test_timeout();
      repeat (10) @(negedge clock50);
      test_start_during_shift();
      test_reset_mid_shift();
      test_transfer("send_f4", 8'hF4, 1'b0, {1'b1, 1'b0, 8'hF4, 1'b0}, 1'b0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
